// File: rtl/ofs_plat_soft_reset_pwr_seq.sv
// ofs_plat_soft_reset_pwr_seq
// FIU-side sequencer for the AFU-facing softReset_n and pwrState signals.
// Host soft-reset request pulses are turned into a drained, minimum-width,
// active-low AFU reset. Power-state updates are registered and each change
// is flagged with a one-cycle pulse.

module ofs_plat_soft_reset_pwr_seq #(
  parameter int MIN_RESET_CYCLES = 16,
  parameter int DRAIN_TIMEOUT    = 1024,
  parameter int PWR_W            = 2,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             soft_reset_req,
  input  logic             afu_quiesced,
  input  logic [PWR_W-1:0] pwr_state_in,
  output logic             softReset_n,
  output logic [PWR_W-1:0] pwrState,
  output logic             pwr_change,
  output logic             reset_busy,
  output logic             drain_timeout,
  output logic [CNT_W-1:0] reset_count
);

  localparam int HOLD_W = $clog2(MIN_RESET_CYCLES);
  localparam int DRN_W  = $clog2(DRAIN_TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(MIN_RESET_CYCLES - 1);
  localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_ASSERT  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic               pend_q, pend_d;
  // por_q marks the ASSERT phase that follows the hardware reset; requests
  // are only accepted in its final cycle.
  logic               por_q, por_d;
  logic               tmo_q, tmo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               srn_q;
  logic               busy_q;
  logic [PWR_W-1:0]   pwr_q;
  logic               chg_q;

  // Next-state logic for the reset sequencer and its counters.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    drain_d = drain_q;
    pend_d  = pend_q;
    por_d   = por_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (soft_reset_req) begin
          state_d = ST_DRAIN;
          drain_d = '0;
          tmo_d   = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + DRN_W'(1);
        if (afu_quiesced) begin
          state_d = ST_ASSERT;
          hold_d  = '0;
        end else if (drain_q == DRAIN_LAST) begin
          state_d = ST_ASSERT;
          hold_d  = '0;
          tmo_d   = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_ASSERT: begin
        hold_d = hold_q + HOLD_W'(1);
        if (soft_reset_req && (!por_q || (hold_q == HOLD_LAST))) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_q;
        end
        if (hold_q == HOLD_LAST) begin
          state_d = ST_RELEASE;
          por_d   = 1'b0;
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : (cnt_q + CNT_W'(1));
        end else begin
          state_d = ST_ASSERT;
        end
      end
      ST_RELEASE: begin
        // A request landing in RELEASE itself coalesces like a pending one.
        if (pend_q || soft_reset_req) begin
          state_d = ST_DRAIN;
          drain_d = '0;
          tmo_d   = 1'b0;
          pend_d  = 1'b0;
        end else begin
          state_d = ST_RUN;
          pend_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        hold_d  = '0;
      end
    endcase
  end

  // Sequencer state and its registered outputs, derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ASSERT;
      hold_q  <= '0;
      drain_q <= '0;
      pend_q  <= 1'b0;
      por_q   <= 1'b1;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      srn_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      drain_q <= drain_d;
      pend_q  <= pend_d;
      por_q   <= por_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      srn_q   <= (state_d != ST_ASSERT);
      busy_q  <= (state_d != ST_RUN);
    end
  end

  // Power-state forwarding with a change pulse aligned to the new value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwr_q <= '0;
      chg_q <= 1'b0;
    end else begin
      pwr_q <= pwr_state_in;
      chg_q <= (pwr_state_in != pwr_q);
    end
  end

  assign softReset_n   = srn_q;
  assign pwrState      = pwr_q;
  assign pwr_change    = chg_q;
  assign reset_busy    = busy_q;
  assign drain_timeout = tmo_q;
  assign reset_count   = cnt_q;

endmodule

// File: tb/tb_ofs_plat_soft_reset_pwr_seq.sv
// Self-checking bench for ofs_plat_soft_reset_pwr_seq (MIN=16, DRAIN_TIMEOUT=8).
// Table rows carry the inputs for one cycle and the outputs expected after
// the following clock edge; expectations travel through a scoreboard queue.

module tb_ofs_plat_soft_reset_pwr_seq;

  logic        clk;
  logic        reset;
  logic        soft_reset_req;
  logic        afu_quiesced;
  logic [1:0]  pwr_state_in;
  logic        softReset_n;
  logic [1:0]  pwrState;
  logic        pwr_change;
  logic        reset_busy;
  logic        drain_timeout;
  logic [15:0] reset_count;

  ofs_plat_soft_reset_pwr_seq #(
    .MIN_RESET_CYCLES(16),
    .DRAIN_TIMEOUT(8),
    .PWR_W(2),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .soft_reset_req(soft_reset_req),
    .afu_quiesced(afu_quiesced),
    .pwr_state_in(pwr_state_in),
    .softReset_n(softReset_n),
    .pwrState(pwrState),
    .pwr_change(pwr_change),
    .reset_busy(reset_busy),
    .drain_timeout(drain_timeout),
    .reset_count(reset_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        srn;
    logic        busy;
    logic        tmo;
    logic [15:0] cnt;
    logic [1:0]  pwr;
    logic        chg;
  } exp_t;

  typedef struct {
    logic        req;
    logic        q;
    logic [1:0]  pwr;
    exp_t        e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  task automatic add(input logic req, input logic q, input logic [1:0] pwr,
                     input logic srn, input logic busy, input logic tmo,
                     input logic [15:0] cnt, input logic [1:0] pexp, input logic chg);
    vec_t v;
    v.req = req; v.q = q; v.pwr = pwr;
    v.e.srn = srn; v.e.busy = busy; v.e.tmo = tmo;
    v.e.cnt = cnt; v.e.pwr = pexp; v.e.chg = chg;
    tbl.push_back(v);
  endtask

  // n ASSERT rows, then RELEASE (count becomes cnt_after), then one RUN row.
  task automatic add_tail(input int n, input logic tmo, input logic [15:0] cnt_after);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, tmo, cnt_after - 16'd1, 2'd0, 1'b0);
    add(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, tmo, cnt_after, 2'd0, 1'b0);
    add(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, tmo, cnt_after, 2'd0, 1'b0);
  endtask

  task automatic apply(input vec_t v, input int row);
    exp_t e;
    soft_reset_req = v.req;
    afu_quiesced   = v.q;
    pwr_state_in   = v.pwr;
    sb_q.push_back(v.e);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check($sformatf("row%0d sb_empty", row), 32'(0), 32'(1));
    end else begin
      e = sb_q.pop_front();
      check($sformatf("row%0d softReset_n", row), 32'(softReset_n), 32'(e.srn));
      check($sformatf("row%0d reset_busy", row), 32'(reset_busy), 32'(e.busy));
      check($sformatf("row%0d drain_timeout", row), 32'(drain_timeout), 32'(e.tmo));
      check($sformatf("row%0d reset_count", row), 32'(reset_count), 32'(e.cnt));
      check($sformatf("row%0d pwrState", row), 32'(pwrState), 32'(e.pwr));
      check($sformatf("row%0d pwr_change", row), 32'(pwr_change), 32'(e.chg));
    end
  endtask

  // Runs n cycles after a reset release, with a request in cycle req_at.
  task automatic por_run(input int n, input int req_at, output int rise_at,
                         output int falls);
    logic prev;
    prev    = softReset_n;
    rise_at = -1;
    falls   = 0;
    for (int i = 0; i < n; i++) begin
      soft_reset_req = (i == req_at);
      afu_quiesced   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!prev && softReset_n && rise_at < 0) rise_at = i;
      if (prev && !softReset_n) falls++;
      prev = softReset_n;
    end
    soft_reset_req = 1'b0;
  endtask

  initial begin
    int   rise_at;
    int   falls;
    logic prev;

    // Power-on: table A
    add_tail(15, 1'b0, 16'd1);
    add(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 16'd1, 2'd0, 1'b0);
    // Power-state forwarding: 2,2,1,1,3,0,0
    add(1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 16'd1, 2'd2, 1'b1);
    add(1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 16'd1, 2'd2, 1'b0);
    add(1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 16'd1, 2'd1, 1'b1);
    add(1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 16'd1, 2'd1, 1'b0);
    add(1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 16'd1, 2'd3, 1'b1);
    add(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 16'd1, 2'd0, 1'b1);
    add(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 16'd1, 2'd0, 1'b0);
    // Quiesced drain: DRAIN one cycle, then 16 cycles low, RELEASE
    add(1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 16'd1, 2'd0, 1'b0);
    add(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 16'd1, 2'd0, 1'b0);
    add_tail(15, 1'b0, 16'd2);
    // Timeout: 8 DRAIN cycles then ASSERT with sticky drain_timeout
    add(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 16'd2, 2'd0, 1'b0);
    for (int i = 0; i < 7; i++) add(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 16'd2, 2'd0, 1'b0);
    add(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 16'd2, 2'd0, 1'b0);
    add_tail(15, 1'b1, 16'd3);
    add(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 16'd3, 2'd0, 1'b0);
    // Quiesce in the timeout cycle wins; new request clears the flag
    add(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 16'd3, 2'd0, 1'b0);
    for (int i = 0; i < 7; i++) add(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 16'd3, 2'd0, 1'b0);
    add(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 16'd3, 2'd0, 1'b0);
    add_tail(15, 1'b0, 16'd4);

    // Reset values, with a nonzero power input that must not pass through
    reset          = 1'b1;
    soft_reset_req = 1'b0;
    afu_quiesced   = 1'b0;
    pwr_state_in   = 2'd3;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst softReset_n", 32'(softReset_n), 32'(0));
    check("rst pwrState", 32'(pwrState), 32'(0));
    check("rst pwr_change", 32'(pwr_change), 32'(0));
    check("rst reset_busy", 32'(reset_busy), 32'(1));
    check("rst drain_timeout", 32'(drain_timeout), 32'(0));
    check("rst reset_count", 32'(reset_count), 32'(0));
    reset = 1'b0;

    for (int r = 0; r < tbl.size(); r++) apply(tbl[r], r + 1);

    // Coalescing: req in RUN, one in DRAIN, three in ASSERT
    prev  = softReset_n;
    falls = 0;
    for (int i = 0; i < 80; i++) begin
      soft_reset_req = (i == 0) || (i == 1) || (i == 3) || (i == 5) || (i == 7);
      afu_quiesced   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (prev && !softReset_n) falls++;
      prev = softReset_n;
    end
    soft_reset_req = 1'b0;
    check("coal falls", 32'(falls), 32'(2));
    check("coal reset_count", 32'(reset_count), 32'(6));
    check("coal reset_busy", 32'(reset_busy), 32'(0));
    check("coal softReset_n", 32'(softReset_n), 32'(1));

    // Async reset mid-ASSERT with a pending request
    soft_reset_req = 1'b1;
    afu_quiesced   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    soft_reset_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("arst pre softReset_n", 32'(softReset_n), 32'(0));
    soft_reset_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    soft_reset_req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst softReset_n", 32'(softReset_n), 32'(0));
    check("arst reset_count", 32'(reset_count), 32'(0));
    check("arst reset_busy", 32'(reset_busy), 32'(1));
    check("arst drain_timeout", 32'(drain_timeout), 32'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    por_run(60, 5, rise_at, falls);
    check("arst rise cycle", 32'(rise_at), 32'(15));
    check("arst followup falls", 32'(falls), 32'(0));
    check("arst reset_count", 32'(reset_count), 32'(1));
    check("arst reset_busy end", 32'(reset_busy), 32'(0));

    // Request in the final cycle of the power-on ASSERT is honoured
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    por_run(60, 15, rise_at, falls);
    check("por_last rise cycle", 32'(rise_at), 32'(15));
    check("por_last falls", 32'(falls), 32'(1));
    check("por_last reset_count", 32'(reset_count), 32'(2));
    check("por_last reset_busy", 32'(reset_busy), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
